// File: rtl/pads_cfg_loader_if.sv
// Wishbone bus between the pad-config loader (master) and the pad register block (slave).
interface pads_cfg_loader_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/pads_cfg_loader.sv
// Writes one OEN bit per pad to consecutive Wishbone registers, with ack timeout.
// Define PADS_CFG_READBACK_EN to read each register back and compare after its write.
module pads_cfg_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_6000,
    parameter int          NUM_PADS  = 38,
    parameter int          TIMEOUT   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [37:0]       oen_cfg,
    pads_cfg_loader_if.master wbm,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [5:0]        err_idx
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef PADS_CFG_READBACK_EN
    localparam logic [2:0] RREQ = 3'd4;
    localparam logic [2:0] RGAP = 3'd5;
    localparam logic [2:0] ADV_ST = RGAP;
`else
    localparam logic [2:0] ADV_ST = GAP;
`endif
    localparam logic [5:0] LAST_IDX = 6'(NUM_PADS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  state, state_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [7:0]  tcnt;
    logic [37:0] shadow, shadow_nxt;
    logic        load, set_err, ack_ok, tmo, in_req, req_nxt;
    logic        cyc_q, stb_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q;
    logic        unused_dat_i;

    assign ack_ok       = wbm.wbm_ack_i & stb_q;
    assign tmo          = (tcnt == TMO_LAST);
    assign shadow_nxt   = load ? oen_cfg : shadow;
    assign unused_dat_i = ^wbm.wbm_dat_i;

`ifdef PADS_CFG_READBACK_EN
    logic rb_bad;
    assign rb_bad  = (wbm.wbm_dat_i[0] != shadow[idx]);
    assign in_req  = (state == REQ) || (state == RREQ);
    assign req_nxt = (state_nxt == REQ) || (state_nxt == RREQ);
`else
    assign in_req  = (state == REQ);
    assign req_nxt = (state_nxt == REQ);
`endif

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = REQ;
                idx_nxt   = '0;
                load      = 1'b1;
            end
            REQ: if (ack_ok) begin
                state_nxt = GAP;
            end else if (tmo) begin
                state_nxt = DONE;
                set_err   = 1'b1;
            end
`ifdef PADS_CFG_READBACK_EN
            GAP: state_nxt = RREQ;
            RREQ: if (ack_ok) begin
                state_nxt = rb_bad ? DONE : RGAP;
                set_err   = rb_bad;
            end else if (tmo) begin
                state_nxt = DONE;
                set_err   = 1'b1;
            end
`endif
            // Stale acks arriving here are ignored: this state never looks at ack.
            ADV_ST: if (idx == LAST_IDX) begin
                state_nxt = DONE;
            end else begin
                idx_nxt   = idx + 6'd1;
                state_nxt = REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered straight from the next state, so they change on the decision edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            tcnt    <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_idx <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the values from before this edge.
            state <= state_nxt;
            idx   <= idx_nxt;
            tcnt  <= (in_req && state_nxt == state) ? tcnt + 8'd1 : '0;
            cyc_q <= req_nxt;
            stb_q <= req_nxt;
            we_q  <= (state_nxt == REQ);
            sel_q <= req_nxt ? 4'hF : 4'h0;
            adr_q <= req_nxt ? BASE_ADDR + {26'd0, idx_nxt} : '0;
            dat_q <= (state_nxt == REQ) ? {31'd0, shadow_nxt[idx_nxt]} : '0;
            busy  <= (state_nxt != IDLE) && (state_nxt != DONE);
            done  <= (state_nxt == DONE);
            if (load) begin
                err     <= 1'b0;
                err_idx <= '0;
            end else if (set_err) begin
                err     <= 1'b1;
                err_idx <= idx;
            end
        end
    end

    // NOTE: shadow is reloaded on every accepted start and never read before that, so it has no reset.
    always_ff @(posedge wb_clk_i) begin
        if (load) shadow <= oen_cfg;
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

endmodule

// File: doc/pads_cfg_loader.md
PADS_CFG_LOADER -- requirements
Module: pads_cfg_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_6000: Wishbone base address of the pad-config register block.
REQ-002 Parameter NUM_PADS, default 38: number of pad OEN registers to program, legal range 1..38.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles to wait for ack per transaction, legal range 2..255.
REQ-004 wb_clk_i  input  1: the only clock; all logic is on its rising edge.
REQ-005 wb_rst_i  input  1: reset, synchronous and active-high.
REQ-006 start  input  1: one-cycle pulse that begins a load sequence.
REQ-007 oen_cfg  input  38: per-pad OEN values to write; bit i goes to pad i; 1 = input, 0 = output.
REQ-008 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each: Wishbone master strobes.
REQ-009 wbm_sel_o  output  4: byte select, constant 4'hF during a transaction.
REQ-010 wbm_adr_o  output  32: transaction address.
REQ-011 wbm_dat_o  output  32: write data.
REQ-012 wbm_ack_i  input  1: slave acknowledge.
REQ-013 wbm_dat_i  input  32: slave read data; only bit 0 is used.
REQ-014 busy  output  1: a sequence is in progress.
REQ-015 done  output  1: one-cycle pulse when a sequence ends, with or without error.
REQ-016 err  output  1: sticky error flag of the last sequence.
REQ-017 err_idx  output  6: pad index at which the error occurred.

Function
REQ-018 FSM states: IDLE, REQ, GAP, DONE, plus RREQ and RGAP when the readback feature is compiled in (REQ-032).
REQ-019 IDLE -> REQ on start; on the same edge, latch oen_cfg into a shadow register, clear err, err_idx and the pad index idx, and assert busy.
REQ-020 start is ignored while busy is high.
REQ-021 REQ: cyc=stb=we=1, adr=BASE_ADDR+idx, dat_o={31'b0, shadow[idx]}; all master outputs are registered.
REQ-022 REQ exit on ack:
- next state GAP; cyc and stb drop on the following edge;
- ack is honoured only while stb is high.
REQ-023 GAP lasts exactly one cycle, and any ack seen in GAP is ignored.
REQ-024 GAP exit:
- if idx == NUM_PADS-1, go to DONE;
- otherwise increment idx and go to REQ.
REQ-025 With a slave that acks one cycle after stb, each write occupies 3 cycles, so a full NUM_PADS=38 sequence lasts 114 cycles from the first stb to done.
REQ-026 Timeout counter:
- cleared on entry to REQ and incremented each REQ cycle without ack;
- on reaching TIMEOUT, drop cyc/stb, set err=1, set err_idx=idx, and go to DONE;
- ack in the same cycle as the terminal count wins (no error).
REQ-027 DONE lasts one cycle: done=1 and busy=0 at the same edge, then return to IDLE.
REQ-028 err and err_idx hold their values until the next accepted start.
REQ-029 When cyc is low: stb=we=0, adr=0, dat_o=0, sel=0.

Reset
REQ-030 wb_rst_i=1 at a clock edge forces:
- state=IDLE, idx=0, timeout counter=0;
- cyc=stb=we=0, sel=0, adr=0, dat_o=0;
- busy=done=err=0, err_idx=0.
REQ-031 Reset mid-transaction drops cyc/stb on that edge without asserting done; a start coincident with reset is ignored.

Configuration
REQ-032 Macro PADS_CFG_READBACK_EN:
- When defined, GAP goes to RREQ (not straight to the next pad); RREQ issues a read (we=0, same adr), then RGAP lasts one cycle.
- On the RREQ ack, wbm_dat_i[0] != shadow[idx] sets err=1 and err_idx=idx, and the sequence ends via DONE.
- On a match, proceed as in REQ-024 from RGAP.
- RREQ is subject to the same timeout as REQ.
- A full 38-pad sequence then lasts 228 cycles.
- When undefined, the RREQ/RGAP states and the compare logic are absent and only writes are issued.

Verification
REQ-033 Reset, then start with oen_cfg=38'h3F_FFC0_0000 and a 1-cycle-ack slave -> 38 writes to 0x3000_6000..0x3000_6025 with dat bit0 matching; done at cycle 114; err=0.
REQ-034 Slave holds ack high for 2 cycles per access -> still exactly one write per address, the stale ack in GAP is ignored, and 38 writes total.
REQ-035 Slave never acks pad 5 with TIMEOUT=16 -> cyc drops after 16 REQ cycles; done=1, err=1, err_idx=5; no access to address 0x3000_6006.
REQ-036 wb_rst_i asserted during the write to pad 10, plus start pulses while busy -> cyc=0 on the next edge, no done pulse, extra starts ignored, and a new start restarts at pad 0.
REQ-037 PADS_CFG_READBACK_EN defined and the slave returns an inverted bit for pad 22 -> writes and reads alternate; done with err=1, err_idx=22; no access beyond 0x3000_6016.
